clk_div_monitor: RTL
====================

Name: clk_div_monitor

Overview:
Measures a divided clock produced inside the system, sampled by the reference clock. Reports high time, low time and period in reference-clock cycles, and checks the period against an expected division ratio. Sits beside each clock divider instance, e.g. the UART TX/RX clock dividers, as the self-check and receive end of the divided-clock interface. Flags a stalled or missing divided clock with a timeout.

Parameters:
DIV_RATIO_WIDTH, 8, width of the expected ratio and of the high/low counters.
SYNC_STAGES, 0, number of synchroniser flops on i_div_clk before edge detection. Legal values are 0, 1 and 2. Use 0 only when i_div_clk is a register output in the i_ref_clk domain.
TIMEOUT_CYC, 255, number of cycles without an edge before the timeout fires. Range is 2..2^DIV_RATIO_WIDTH-1.

Ports:
i_ref_clk  in  1  reference clock; the only clock in the block.
i_rst_n  in  1  reset, synchronous, active-low.
i_mon_en  in  1  monitor enable.
i_div_clk  in  1  divided clock under measurement, treated as data.
i_exp_ratio  in  DIV_RATIO_WIDTH  expected division ratio.
o_high_cnt  out  DIV_RATIO_WIDTH  last measured high time, in cycles.
o_low_cnt  out  DIV_RATIO_WIDTH  last measured low time, in cycles.
o_meas_ratio  out  DIV_RATIO_WIDTH+1  last measured period, equal to o_high_cnt + o_low_cnt.
o_valid  out  1  one-cycle pulse when a new measurement is published.
o_match  out  1  comparison result of the last published period.
o_timeout  out  1  sticky stall flag.

Behaviour:
- Reset: when i_rst_n is sampled low at a posedge of i_ref_clk:
  - every output, counter and the edge-history register clears to 0;
  - the state machine goes to IDLE;
  - reset mid-measurement discards any partial counts.
- Sampling path: i_div_clk passes through SYNC_STAGES flops to give s_clk. A history register holds the previous s_clk, p_clk.
  - rise = s_clk & ~p_clk.
  - fall = ~s_clk & p_clk.
- State machine states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- IDLE: when i_mon_en = 1, go to WAIT_RISE and set cnt to 0.
- WAIT_RISE:
  - on rise: cnt <= 1 and go to MEAS_HIGH;
  - otherwise: cnt increments.
- MEAS_HIGH:
  - on fall: hold the high time internally (hi_tmp <= cnt), set cnt <= 1 and go to MEAS_LOW;
  - otherwise: cnt increments.
- MEAS_LOW:
  - otherwise (no rise): cnt increments;
  - on rise, at that same clock edge:
    - o_high_cnt <= hi_tmp;
    - o_low_cnt <= cnt;
    - o_meas_ratio <= hi_tmp + cnt, at DIV_RATIO_WIDTH+1 bits with no overflow;
    - o_match and o_valid update as below; o_timeout clears;
    - cnt <= 1 and the FSM goes to MEAS_HIGH, so measurement is back-to-back and continuous.
- Latency: outputs are visible one cycle after the closing rise is sampled, plus the SYNC_STAGES delay from the i_div_clk pin.
- o_valid: high for exactly one cycle per published period; low in every other cycle.
- o_match = 1 only when all of the following hold:
  - i_exp_ratio >= 2;
  - the measured period equals i_exp_ratio;
  - |hi_tmp - cnt| <= i_exp_ratio[0], i.e. 0 for even ratios and 1 for odd ratios.
  i_exp_ratio is sampled only at the publish edge. Expected ratio 0 or 1 (divider bypass) always gives o_match = 0.
- Counter saturation and timeout:
  - cnt never wraps.
  - In WAIT_RISE, MEAS_HIGH or MEAS_LOW, if cnt reaches TIMEOUT_CYC with no relevant edge: o_timeout <= 1 and o_match <= 0; cnt <= 0 and the FSM goes to WAIT_RISE; no o_valid pulse.
  - o_timeout stays set until the next publish, disable or reset.
- Disable: when i_mon_en is sampled 0 in any state:
  - the FSM goes to IDLE at the next edge and cnt clears;
  - o_valid <= 0 and o_timeout <= 0;
  - o_high_cnt, o_low_cnt, o_meas_ratio and o_match hold their last values.
- Simultaneous events:
  - reset has priority over disable; disable has priority over edge and timeout handling;
  - an edge on the same cycle cnt reaches TIMEOUT_CYC counts as the edge, not a timeout.
- The first published period after enable is the first full period following the first observed rise. A partial high phase present at enable is ignored.

Decomposition:
- Shared package:
  - state encoding localparams IDLE = 2'b00, WAIT_RISE = 2'b01, MEAS_HIGH = 2'b10, MEAS_LOW = 2'b11;
  - DIV_RATIO_WIDTH default;
  - legal SYNC_STAGES range.
- One sub-module, level_sync_edge:
  - parameterised flop synchroniser plus history flop;
  - outputs s_clk, rise and fall;
  - uses the same synchronous active-low reset.
- The FSM, counters and compare logic live in clk_div_monitor.

Test Plan:
- Ratio 4, i_exp_ratio = 4, SYNC_STAGES = 0 -> each o_valid shows high 2, low 2, meas 4, match 1; o_valid pulses every 4 cycles.
- Ratio 5, i_exp_ratio = 5 -> high/low are {2,3} or {3,2}, meas 5, match 1.
- Ratio 4 driven with i_exp_ratio = 6 -> meas 4, match 0; o_valid still pulses.
- i_div_clk held at 1, TIMEOUT_CYC = 20 -> o_timeout = 1 after 20 cycles, no o_valid; then restore ratio 2 -> timeout clears at the first publish, meas 2.
- i_mon_en dropped during MEAS_LOW at ratio 8 -> no o_valid, previous results held; re-enable -> first o_valid only after a full new period.
- Ratio 6 with SYNC_STAGES = 2, reset asserted mid-MEAS_HIGH -> all outputs 0 the next cycle; after release, values are high 3, low 3, meas 6, and the first o_valid arrives 2 cycles later than with SYNC_STAGES = 0.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// rtl/clk_div_monitor_pkg.sv - shared types and constants for the divided-clock monitor
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_RISE = 2'b01,
    MEAS_HIGH = 2'b10,
    MEAS_LOW  = 2'b11
  } state_t;

  localparam int DEFAULT_DIV_RATIO_WIDTH = 8;
  localparam int SYNC_STAGES_MIN         = 0;
  localparam int SYNC_STAGES_MAX         = 2;

endpackage

// File: rtl/clk_div_monitor_sync.sv
// rtl/clk_div_monitor_sync.sv - level_sync_edge: optional synchroniser plus edge detect on the divided clock
module level_sync_edge
  import clk_div_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic i_ref_clk,
  input  logic i_rst_n,
  input  logic i_div_clk,
  output logic s_clk,
  output logic rise,
  output logic fall
);

  // Out-of-range depths are clamped to the legal window.
  localparam int STAGES = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                          (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic p_clk;

  generate
    if (STAGES == 0) begin : g_direct
      assign s_clk = i_div_clk;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= STAGES'({sync_q, i_div_clk});
        end
      end
      assign s_clk = sync_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      p_clk <= 1'b0;
    end else begin
      p_clk <= s_clk;
    end
  end

  assign rise = s_clk & ~p_clk;
  assign fall = ~s_clk & p_clk;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures high/low/period of a divided clock and checks it against an expected ratio
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int DIV_RATIO_WIDTH = DEFAULT_DIV_RATIO_WIDTH,
  parameter int SYNC_STAGES     = 0,
  parameter int TIMEOUT_CYC     = 255
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mon_en,
  input  logic                       i_div_clk,
  input  logic [DIV_RATIO_WIDTH-1:0] i_exp_ratio,
  output logic [DIV_RATIO_WIDTH-1:0] o_high_cnt,
  output logic [DIV_RATIO_WIDTH-1:0] o_low_cnt,
  output logic [DIV_RATIO_WIDTH:0]   o_meas_ratio,
  output logic                       o_valid,
  output logic                       o_match,
  output logic                       o_timeout
);

  localparam int W = DIV_RATIO_WIDTH;
  localparam logic [W-1:0] CNT_ONE     = W'(1);
  localparam logic [W-1:0] RATIO_MIN   = W'(2);
  localparam logic [W-1:0] TIMEOUT_VAL = W'(TIMEOUT_CYC);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_tmp_q, hi_tmp_d;
  logic [W-1:0] high_q, high_d;
  logic [W-1:0] low_q, low_d;
  logic [W:0]   meas_q, meas_d;
  logic         valid_q, valid_d;
  logic         match_q, match_d;
  logic         timeout_q, timeout_d;

  logic         unused_s_clk;
  logic         rise, fall;
  logic         edge_hit;
  logic [W:0]   period_sum;
  logic [W-1:0] phase_diff;
  logic         period_ok;

  level_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_ref_clk(i_ref_clk),
    .i_rst_n  (i_rst_n),
    .i_div_clk(i_div_clk),
    .s_clk    (unused_s_clk),
    .rise     (rise),
    .fall     (fall)
  );

  // Only the edge that ends the current phase matters in each state.
  assign edge_hit   = (state_q == MEAS_HIGH) ? fall : rise;
  assign period_sum = {1'b0, hi_tmp_q} + {1'b0, cnt_q};
  assign phase_diff = (hi_tmp_q >= cnt_q) ? (hi_tmp_q - cnt_q) : (cnt_q - hi_tmp_q);
  assign period_ok  = (i_exp_ratio >= RATIO_MIN) &&
                      (period_sum == {1'b0, i_exp_ratio}) &&
                      (phase_diff <= {{(W-1){1'b0}}, i_exp_ratio[0]});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_tmp_d  = hi_tmp_q;
    high_d    = high_q;
    low_d     = low_q;
    meas_d    = meas_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    timeout_d = timeout_q;

    if (!i_mon_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = WAIT_RISE;
      cnt_d   = '0;
    end else if (edge_hit) begin
      cnt_d = CNT_ONE;
      case (state_q)
        MEAS_HIGH: begin
          hi_tmp_d = cnt_q;
          state_d  = MEAS_LOW;
        end
        MEAS_LOW: begin
          high_d    = hi_tmp_q;
          low_d     = cnt_q;
          meas_d    = period_sum;
          match_d   = period_ok;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = MEAS_HIGH;
        end
        default: state_d = MEAS_HIGH;
      endcase
    end else if (cnt_q >= TIMEOUT_VAL) begin
      // Stall: restart the search for a rising edge without publishing.
      timeout_d = 1'b1;
      match_d   = 1'b0;
      cnt_d     = '0;
      state_d   = WAIT_RISE;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_tmp_q  <= '0;
      high_q    <= '0;
      low_q     <= '0;
      meas_q    <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_tmp_q  <= hi_tmp_d;
      high_q    <= high_d;
      low_q     <= low_d;
      meas_q    <= meas_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_high_cnt   = high_q;
  assign o_low_cnt    = low_q;
  assign o_meas_ratio = meas_q;
  assign o_valid      = valid_q;
  assign o_match      = match_q;
  assign o_timeout    = timeout_q;

endmodule
